// File: rtl/bus_timing_ctrl.sv
// 6502 PHI2 generator with per-region high-phase stretching, phase-qualified
// chip enables / strobes, and a CPU reset held for a fixed number of PHI2 cycles.
module bus_timing_ctrl #(
  parameter int DIV        = 4,
  parameter int ROM_WAIT   = 2,
  parameter int PIA_WAIT   = 4,
  parameter int RES_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] addr_hi,
  input  logic       rw,
  output logic       phi2,
  output logic       cpu_res_n,
  output logic       ram_ce_n,
  output logic       pia_cs_n,
  output logic       rom_ce_n,
  output logic       oe_n,
  output logic       we_n
);

  localparam int MAX_WAIT = (ROM_WAIT > PIA_WAIT) ? ROM_WAIT : PIA_WAIT;

  generate
    if (DIV < 2 || DIV > 15 || ROM_WAIT < 0 || ROM_WAIT > 16 || PIA_WAIT < 0 ||
        PIA_WAIT > 16 || DIV + MAX_WAIT > 31 || RES_CYCLES < 1 || RES_CYCLES > 15)
    begin : g_param_check
      $error("bus_timing_ctrl: parameter out of range");
    end
  endgenerate

  localparam logic [4:0] DIV_L   = 5'(DIV);
  localparam logic [4:0] ROM_LIM = 5'(DIV + ROM_WAIT);
  localparam logic [4:0] PIA_LIM = 5'(DIV + PIA_WAIT);
  localparam logic [3:0] RES_L   = 4'(RES_CYCLES);

  typedef enum logic {ST_LOW = 1'b0, ST_HIGH = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] limit_q, limit_d;
  logic [3:0] fall_q, fall_d;
  logic       ram_l_q, ram_l_d, pia_l_q, pia_l_d, rom_l_q, rom_l_d, rw_l_q, rw_l_d;
  logic       phi2_q, phi2_d, res_n_q, res_n_d;
  logic       ram_ce_n_q, ram_ce_n_d, pia_cs_n_q, pia_cs_n_d, rom_ce_n_q, rom_ce_n_d;
  logic       oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic       ram_sel_s, pia_sel_s, rom_sel_s;

  assign ram_sel_s = ~addr_hi[3];
  assign pia_sel_s = (addr_hi == 4'hD);
  assign rom_sel_s = (addr_hi[3:1] == 3'b111);

  // Next-state and next-output logic; outputs are computed for the cycle after the edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 5'd1;
    limit_d    = limit_q;
    fall_d     = fall_q;
    res_n_d    = res_n_q;
    ram_l_d    = ram_l_q;
    pia_l_d    = pia_l_q;
    rom_l_d    = rom_l_q;
    rw_l_d     = rw_l_q;
    phi2_d     = 1'b0;
    ram_ce_n_d = 1'b1;
    pia_cs_n_d = 1'b1;
    rom_ce_n_d = 1'b1;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    case (state_q)
      ST_LOW: begin
        if (cnt_q == DIV_L - 5'd1) begin
          state_d    = ST_HIGH;
          cnt_d      = 5'd0;
          ram_l_d    = ram_sel_s;
          pia_l_d    = pia_sel_s;
          rom_l_d    = rom_sel_s;
          rw_l_d     = rw;
          limit_d    = rom_sel_s ? ROM_LIM : (pia_sel_s ? PIA_LIM : DIV_L);
          phi2_d     = 1'b1;
          ram_ce_n_d = ~ram_sel_s;
          pia_cs_n_d = ~pia_sel_s;
          rom_ce_n_d = ~rom_sel_s;
          oe_n_d     = ~rw;
          we_n_d     = rw;
        end else begin
          state_d = ST_LOW;
        end
      end
      ST_HIGH: begin
        if (cnt_q == limit_q - 5'd1) begin
          state_d = ST_LOW;
          cnt_d   = 5'd0;
          // Reset-release counter saturates once cpu_res_n has been released.
          if (fall_q < RES_L) begin
            fall_d = fall_q + 4'd1;
            if (fall_q + 4'd1 == RES_L) begin
              res_n_d = 1'b1;
            end else begin
              res_n_d = res_n_q;
            end
          end else begin
            fall_d = fall_q;
          end
        end else begin
          phi2_d     = 1'b1;
          ram_ce_n_d = ~ram_l_q;
          pia_cs_n_d = ~pia_l_q;
          rom_ce_n_d = ~rom_l_q;
          oe_n_d     = ~rw_l_q;
          we_n_d     = rw_l_q;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // State, latched cycle attributes and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOW;
      cnt_q      <= 5'd0;
      limit_q    <= DIV_L;
      fall_q     <= 4'd0;
      ram_l_q    <= 1'b0;
      pia_l_q    <= 1'b0;
      rom_l_q    <= 1'b0;
      rw_l_q     <= 1'b1;
      phi2_q     <= 1'b0;
      res_n_q    <= 1'b0;
      ram_ce_n_q <= 1'b1;
      pia_cs_n_q <= 1'b1;
      rom_ce_n_q <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      limit_q    <= limit_d;
      fall_q     <= fall_d;
      ram_l_q    <= ram_l_d;
      pia_l_q    <= pia_l_d;
      rom_l_q    <= rom_l_d;
      rw_l_q     <= rw_l_d;
      phi2_q     <= phi2_d;
      res_n_q    <= res_n_d;
      ram_ce_n_q <= ram_ce_n_d;
      pia_cs_n_q <= pia_cs_n_d;
      rom_ce_n_q <= rom_ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
    end
  end

  assign phi2      = phi2_q;
  assign cpu_res_n = res_n_q;
  assign ram_ce_n  = ram_ce_n_q;
  assign pia_cs_n  = pia_cs_n_q;
  assign rom_ce_n  = rom_ce_n_q;
  assign oe_n      = oe_n_q;
  assign we_n      = we_n_q;

endmodule

// File: tb/tb_bus_timing_ctrl.sv
// Scoreboard bench for bus_timing_ctrl: a count-down phase model pushes the
// expected output vector per clk edge; it is popped and compared after the edge.
module tb_bus_timing_ctrl;

  localparam int DIV = 4, ROM_WAIT = 2, PIA_WAIT = 4, RES_CYCLES = 2;
  localparam logic [6:0] RESET_V = 7'b0011111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] addr_hi = 4'h0;
  logic       rw = 1'b1;
  logic phi2, cpu_res_n, ram_ce_n, pia_cs_n, rom_ce_n, oe_n, we_n;

  int tests_run = 0;
  int tests_failed = 0;
  logic [6:0] exp_q[$];

  // model state: region 0 none, 1 ram, 2 pia, 3 rom
  logic m_high;
  int   m_left, m_falls;
  logic m_resn;
  int   m_rgn;
  logic m_rw;

  bus_timing_ctrl #(.DIV(DIV), .ROM_WAIT(ROM_WAIT), .PIA_WAIT(PIA_WAIT),
                    .RES_CYCLES(RES_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .addr_hi(addr_hi), .rw(rw), .phi2(phi2),
    .cpu_res_n(cpu_res_n), .ram_ce_n(ram_ce_n), .pia_cs_n(pia_cs_n),
    .rom_ce_n(rom_ce_n), .oe_n(oe_n), .we_n(we_n)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] obs_vec();
    return {phi2, cpu_res_n, ram_ce_n, pia_cs_n, rom_ce_n, oe_n, we_n};
  endfunction

  function automatic logic [6:0] model_vec();
    logic [6:0] v;
    v[6] = m_high;
    v[5] = m_resn;
    v[4] = !(m_high && m_rgn == 1);
    v[3] = !(m_high && m_rgn == 2);
    v[2] = !(m_high && m_rgn == 3);
    v[1] = m_high ? !m_rw : 1'b1;
    v[0] = m_high ? m_rw : 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_high = 1'b0; m_left = DIV; m_falls = 0; m_resn = 1'b0; m_rgn = 0; m_rw = 1'b1;
  endtask

  // Advance the model one clk edge, push its expectation, then compare after the edge.
  task automatic step();
    int w;
    logic [6:0] e;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (!m_high) begin
          m_rgn = (addr_hi <= 4'h7) ? 1 : (addr_hi == 4'hD) ? 2 : (addr_hi >= 4'hE) ? 3 : 0;
          m_rw  = rw;
          w = (m_rgn == 3) ? ROM_WAIT : (m_rgn == 2) ? PIA_WAIT : 0;
          m_high = 1'b1; m_left = DIV + w;
        end else begin
          m_high = 1'b0; m_left = DIV;
          if (m_falls < RES_CYCLES) m_falls++;
          if (m_falls == RES_CYCLES) m_resn = 1'b1;
        end
      end
    end
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("sb_outputs", {25'd0, obs_vec()}, {25'd0, e});
  endtask

  // Run one PHI2 cycle from a low phase, optionally switching addr mid high phase.
  task automatic run_cycle(input logic [3:0] a, input logic r, input int exp_high,
                           input int switch_at, input logic [3:0] a2);
    int n, hi;
    addr_hi = a; rw = r;
    n = 0;
    while (!phi2 && n < 40) begin step(); n++; end
    check_val("low_len", n, DIV);
    hi = 1;
    while (phi2 && hi < 40) begin
      if (hi == switch_at) addr_hi = a2;
      step();
      if (phi2) hi++;
    end
    check_val("high_len", hi, exp_high);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_vec", {25'd0, obs_vec()}, {25'd0, RESET_V});
    rst_n = 1'b1;

    // reset release, addr 0x0 read: rise at edge 4, fall at edge 8, res_n at edge 16
    run_cycle(4'h0, 1'b1, 4, -1, 4'h0);
    check_val("res_n_after_1", cpu_res_n, 1'b0);
    run_cycle(4'h0, 1'b1, 4, -1, 4'h0);
    check_val("res_n_after_2", cpu_res_n, 1'b1);

    run_cycle(4'h3, 1'b1, 4, -1, 4'h0);          // RAM read
    run_cycle(4'hF, 1'b1, DIV + ROM_WAIT, -1, 4'h0); // EEPROM read
    run_cycle(4'h3, 1'b1, 4, -1, 4'h0);          // back to period 8
    run_cycle(4'hD, 1'b0, DIV + PIA_WAIT, -1, 4'h0); // PIA write
    run_cycle(4'h9, 1'b1, 4, -1, 4'h0);          // unmapped read
    run_cycle(4'hB, 1'b0, 4, -1, 4'h0);          // unmapped write
    run_cycle(4'hE, 1'b1, DIV + ROM_WAIT, 2, 4'h0); // addr change in HIGH ignored
    run_cycle(4'h7, 1'b0, 4, 1, 4'hD);           // RAM write, addr change ignored
    check_val("res_n_held", cpu_res_n, 1'b1);

    // rst_n pulsed in 3rd clk of an EEPROM high phase
    addr_hi = 4'hE; rw = 1'b1;
    for (int i = 0; i < 40 && !phi2; i++) step();
    step(); step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("async_reset_vec", {25'd0, obs_vec()}, {25'd0, RESET_V});
    step(); step();
    rst_n = 1'b1;
    run_cycle(4'h0, 1'b1, 4, -1, 4'h0);
    check_val("res_n_restart_1", cpu_res_n, 1'b0);
    run_cycle(4'hE, 1'b1, DIV + ROM_WAIT, -1, 4'h0);
    check_val("res_n_restart_2", cpu_res_n, 1'b1);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bus_timing_ctrl.md
Name: bus_timing_ctrl

Overview:
- Generates the 6502 PHI2 clock from the fast system clock.
- Stretches the PHI2 high phase per address region to insert wait states for the slow EEPROM and the PIA.
- Issues phase-qualified chip enables and read/write strobes, and holds the CPU in reset for a fixed number of PHI2 cycles after system reset.
- Sits in the CPLD between the CPU address/RW pins and the memory/PIA enables; uses the same region map as the board decode.

Parameters:
- DIV, 4, clk cycles per PHI2 low phase and base high phase (2..15)
- ROM_WAIT, 2, extra clk cycles in the high phase for EEPROM region (0..16)
- PIA_WAIT, 4, extra clk cycles in the high phase for PIA region (0..16)
- RES_CYCLES, 2, PHI2 falling edges before cpu_res_n deasserts (1..15)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- addr_hi  input  4  CPU A15..A12
- rw  input  1  CPU R/W (1 = read)
- phi2  output  1  CPU PHI2 clock
- cpu_res_n  output  1  CPU reset, active low
- ram_ce_n  output  1  SRAM enable, region 0x0-0x7
- pia_cs_n  output  1  PIA select, region 0xD
- rom_ce_n  output  1  EEPROM enable, region 0xE-0xF
- oe_n  output  1  read strobe
- we_n  output  1  write strobe

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-low on rst_n. All outputs are registered.
- Reset values: phi2=0, cpu_res_n=0, all *_ce_n/cs_n=1, oe_n=1, we_n=1. FSM enters LOW with cnt=0 and the fall counter at 0.
- Counter: cnt is 5 bits. Elaboration check: DIV+max(ROM_WAIT,PIA_WAIT) <= 31.
- FSM has two states, LOW and HIGH.
- LOW state:
  - phi2=0, all enables and strobes inactive.
  - cnt increments each clk.
  - On the edge where cnt==DIV-1:
    - latch region from addr_hi and rw_l from rw;
    - set limit = DIV + wait(region), where wait = ROM_WAIT for 0xE/0xF, PIA_WAIT for 0xD, else 0;
    - go to HIGH with cnt=0.
  - On that same edge: phi2=1, the latched region enable goes low, oe_n=!rw_l, we_n=rw_l.
- HIGH state:
  - phi2=1; enables and strobes held from the latched values only.
  - addr_hi/rw changes during HIGH are ignored.
  - On the edge where cnt==limit-1: phi2=0, all enables and strobes go to 1, go to LOW with cnt=0.
- Resulting timing: PHI2 period = 2*DIV + wait(region) clk cycles. Low phase is always DIV. High phase = DIV + wait.
- Unmapped regions 0x8-0xC: no enable asserted, no wait; oe_n/we_n still driven per rw_l.
- At most one enable is low at any time. The enables are never low while phi2=0.
- cpu_res_n:
  - A saturating fall counter increments on each HIGH->LOW transition.
  - cpu_res_n goes to 1 on the same clk edge as the RES_CYCLES-th phi2 fall.
  - It stays 1 until rst_n is asserted; the counter then stops.
- Reset mid-operation: rst_n low at any point immediately forces all reset values. The partial phase is discarded. After release, the first LOW phase lasts a full DIV cycles.
- The PHI2 cycle and strobes run during CPU reset, so the CPU sees clocks while its reset is held.

Test Plan:
- Reset release, defaults, addr_hi=0x0 rw=1 → phi2 rises at clk edge 4 after release and falls at edge 8; cpu_res_n=0 until edge 16 (2nd fall), then 1 and held.
- RAM read, addr_hi=0x3 rw=1 → phi2 high 4 clks, ram_ce_n=0 and oe_n=0 exactly while phi2=1, we_n=1, other enables 1; period 8.
- EEPROM read, addr_hi=0xF, ROM_WAIT=2 → phi2 high 6 clks, rom_ce_n=0 for those 6 clks, period 10; next RAM cycle returns to period 8.
- PIA write, addr_hi=0xD rw=0, PIA_WAIT=4 → phi2 high 8 clks, pia_cs_n=0, we_n=0, oe_n=1 throughout; unmapped addr_hi=0x9 → no enable low, high phase 4.
- Address change in HIGH: latch 0xE, then switch addr_hi to 0x0 at high-phase clk 2 → rom_ce_n stays 0, ram_ce_n stays 1, high phase still 6.
- rst_n pulsed low during the 3rd clk of an EEPROM high phase → same-cycle phi2=0, all enables/strobes 1, cpu_res_n=0; after release, LOW lasts 4 clks and the reset count restarts (cpu_res_n high after 2 new falls).
